// File: rtl/alu_issue.sv
// ALU issue stage: decodes ALUOp/Funct3/Funct7 into an ALU op code and forwards operands through a main + skid register pair.
// Optional build macro ALU_ISSUE_ILLEGAL_EN adds the IllegalOp port and drops illegal decodes instead of passing them as 0011.
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     ALUSrc,
    input  logic [DATA_WIDTH-1:0]    Rs1Data,
    input  logic [DATA_WIDTH-1:0]    Rs2Data,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     Flush,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     OutValid,
    input  logic                     OutReady
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic                     IllegalOp
`endif
);

    // state    | meaning
    // ST_EMPTY | main and skid empty, OutValid low
    // ST_MAIN  | main holds an instruction, skid empty
    // ST_FULL  | main and skid both hold instructions, InReady low

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1110);

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam logic ILL_DROP = 1'b1;
`else
    localparam logic ILL_DROP = 1'b0;
`endif

    state_t                  state, state_nx;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                    dec_illegal;
    logic                    is_rtype;
    logic [DATA_WIDTH-1:0]   b_sel;
    logic [DATA_WIDTH-1:0]   dec_srcb;
    logic                    is_shift;
    logic                    accept;
    logic                    keep;
    logic                    drain;
    logic                    load_main;
    logic                    load_skid;
    logic                    move_skid;
    logic [DATA_WIDTH-1:0]   skid_a;
    logic [DATA_WIDTH-1:0]   skid_b;
    logic [OPCODE_LENGTH-1:0] skid_op;

    assign is_rtype = (ALUOp == 2'b10);

    always_comb begin
        dec_op      = OP_ILL;
        dec_illegal = 1'b0;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = (Funct3 == 3'b000 || Funct3 == 3'b001) ? OP_EQ : OP_SUB;
            default: begin
                case (Funct3)
                    3'b000: begin
                        if (!is_rtype || Funct7 == F7_ZERO) dec_op = OP_ADD;
                        else if (Funct7 == F7_ALT)          dec_op = OP_SUB;
                        else                                dec_illegal = 1'b1;
                    end
                    3'b001: begin
                        if (Funct7 == F7_ZERO) dec_op = OP_SLL;
                        else                   dec_illegal = 1'b1;
                    end
                    3'b100: begin
                        // I-type funct7 is immediate bits, only R-type constrains it
                        if (!is_rtype || Funct7 == F7_ZERO) dec_op = OP_XOR;
                        else                                dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        if (Funct7 == F7_ZERO)     dec_op = OP_SRL;
                        else if (Funct7 == F7_ALT) dec_op = OP_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                    3'b110: begin
                        if (!is_rtype || Funct7 == F7_ZERO) dec_op = OP_OR;
                        else                                dec_illegal = 1'b1;
                    end
                    3'b111: begin
                        if (!is_rtype || Funct7 == F7_ZERO) dec_op = OP_AND;
                        else                                dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign b_sel    = ALUSrc ? Imm : Rs2Data;
    assign is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
    assign dec_srcb = is_shift ? {{(DATA_WIDTH-5){1'b0}}, b_sel[4:0]} : b_sel;

    assign accept = InValid & InReady;
    assign keep   = accept & ~(dec_illegal & ILL_DROP);
    assign drain  = OutValid & OutReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            OutValid <= 1'b0;
            InReady  <= 1'b1;
        end else begin
            state    <= state_nx;
            OutValid <= (state_nx != ST_EMPTY);
            InReady  <= (state_nx != ST_FULL);
        end
    end

    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (Flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (keep) begin
                        state_nx  = ST_MAIN;
                        load_main = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (drain) begin
                        if (keep) load_main = 1'b1;
                        else      state_nx  = ST_EMPTY;
                    end else if (keep) begin
                        state_nx  = ST_FULL;
                        load_skid = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_nx  = ST_MAIN;
                        move_skid = 1'b1;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            SrcA      <= '0;
            SrcB      <= '0;
            Operation <= '0;
            skid_a    <= '0;
            skid_b    <= '0;
            skid_op   <= '0;
        end else begin
            if (load_main) begin
                SrcA      <= Rs1Data;
                SrcB      <= dec_srcb;
                Operation <= dec_op;
            end else if (move_skid) begin
                SrcA      <= skid_a;
                SrcB      <= skid_b;
                Operation <= skid_op;
            end
            if (load_skid) begin
                skid_a  <= Rs1Data;
                skid_b  <= dec_srcb;
                skid_op <= dec_op;
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) IllegalOp <= 1'b0;
        else       IllegalOp <= accept & dec_illegal;
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, hand sequences for skid/flush/reset, and random traffic against a queue model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        InValid;
    logic        InReady;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        ALUSrc;
    logic [31:0] Rs1Data, Rs2Data, Imm;
    logic        Flush;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        OutValid;
    logic        OutReady;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        IllegalOp;
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .ALUSrc(ALUSrc),
        .Rs1Data(Rs1Data), .Rs2Data(Rs2Data), .Imm(Imm), .Flush(Flush),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .OutValid(OutValid), .OutReady(OutReady)
`ifdef ALU_ISSUE_ILLEGAL_EN
        , .IllegalOp(IllegalOp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } item_t;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        alusrc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [31:0] srcb;
        logic        ill;
    } vec_t;

    item_t mq[$];
    vec_t  vt[16];
    int    total = 0;
    int    bad   = 0;
    logic  exp_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decoding rules written out as a lookup over (class, funct3, funct7).
    function automatic void ref_decode(input logic [1:0] aluop, input logic [2:0] f3,
                                       input logic [6:0] f7,
                                       output logic [3:0] op, output logic ill);
        bit imm_form;
        imm_form = (aluop == 2'b11);
        ill = 1'b0;
        op  = 4'b0011;
        if (aluop == 2'b00) op = 4'b0100;
        else if (aluop == 2'b01) op = (f3 <= 3'd1) ? 4'b1000 : 4'b0101;
        else begin
            case (f3)
                3'd0: if (imm_form || f7 == 7'h00) op = 4'b0100;
                      else if (f7 == 7'h20) op = 4'b0101;
                      else ill = 1'b1;
                3'd1: if (f7 == 7'h00) op = 4'b1100; else ill = 1'b1;
                3'd4: if (imm_form || f7 == 7'h00) op = 4'b0010; else ill = 1'b1;
                3'd5: if (f7 == 7'h00) op = 4'b1101;
                      else if (f7 == 7'h20) op = 4'b1110;
                      else ill = 1'b1;
                3'd6: if (imm_form || f7 == 7'h00) op = 4'b0001; else ill = 1'b1;
                3'd7: if (imm_form || f7 == 7'h00) op = 4'b0000; else ill = 1'b1;
                default: ill = 1'b1;
            endcase
        end
        if (ill) op = 4'b0011;
    endfunction

    task automatic check_state();
        chk("outvalid", {31'b0, OutValid}, {31'b0, mq.size() > 0});
        chk("inready",  {31'b0, InReady},  {31'b0, mq.size() < 2});
        if (mq.size() > 0) begin
            chk("srca", SrcA, mq[0].a);
            chk("srcb", SrcB, mq[0].b);
            chk("operation", {28'b0, Operation}, {28'b0, mq[0].op});
        end
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("illegalop", {31'b0, IllegalOp}, {31'b0, exp_ill});
`endif
    endtask

    // One clock: model sees the pre-edge inputs, then outputs are compared after the edge.
    task automatic tick();
        logic [3:0]  op;
        logic        ill, acc, drn, fl;
        logic [31:0] b;
        ref_decode(ALUOp, Funct3, Funct7, op, ill);
        b = ALUSrc ? Imm : Rs2Data;
        if (op == 4'b1100 || op == 4'b1101 || op == 4'b1110) b = b % 32;
        acc = InValid && (mq.size() < 2);
        drn = (mq.size() > 0) && OutReady;
        fl  = Flush;
        @(posedge clk);
        #1;
        exp_ill = acc && ill;
        if (fl) mq.delete();
        else begin
            if (drn) void'(mq.pop_front());
            if (acc && !(ill && ILL_EN)) mq.push_back('{a: Rs1Data, b: b, op: op});
        end
        check_state();
    endtask

    task automatic drv(input logic v, input logic [1:0] aluop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic src, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm);
        InValid = v; ALUOp = aluop; Funct3 = f3; Funct7 = f7; ALUSrc = src;
        Rs1Data = rs1; Rs2Data = rs2; Imm = imm;
    endtask

    task automatic fill_both();
        OutReady = 1'b0; Flush = 1'b0;
        drv(1'b1, 2'b00, 3'd2, 7'h00, 1'b1, 32'h1111_0001, 32'h0, 32'h0000_0010);
        tick();
        drv(1'b1, 2'b00, 3'd2, 7'h00, 1'b1, 32'h1111_0002, 32'h0, 32'h0000_0020);
        tick();
        InValid = 1'b0;
    endtask

    initial begin
        vt[0]  = '{2'b10, 3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'h0000_0024, 32'h0,         4'b1110, 32'h0000_0004, 1'b0};
        vt[1]  = '{2'b11, 3'b000, 7'h20, 1'b1, 32'h0000_0005, 32'h0000_0009, 32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFF, 1'b0};
        vt[2]  = '{2'b00, 3'b111, 7'h7F, 1'b1, 32'h0000_1000, 32'h0000_1234, 32'h0000_0010, 4'b0100, 32'h0000_0010, 1'b0};
        vt[3]  = '{2'b01, 3'b001, 7'h00, 1'b0, 32'h0000_ABCD, 32'h0000_ABCD, 32'h0,         4'b1000, 32'h0000_ABCD, 1'b0};
        vt[4]  = '{2'b01, 3'b100, 7'h00, 1'b0, 32'h0000_0003, 32'h0000_0007, 32'h0,         4'b0101, 32'h0000_0007, 1'b0};
        vt[5]  = '{2'b10, 3'b000, 7'h20, 1'b0, 32'h0000_0010, 32'h0000_0001, 32'h0,         4'b0101, 32'h0000_0001, 1'b0};
        vt[6]  = '{2'b10, 3'b111, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,         4'b0000, 32'h0FF0_0FF0, 1'b0};
        vt[7]  = '{2'b10, 3'b110, 7'h00, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0,         4'b0001, 32'h0000_0002, 1'b0};
        vt[8]  = '{2'b10, 3'b100, 7'h00, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0,         4'b0010, 32'h5555_5555, 1'b0};
        vt[9]  = '{2'b10, 3'b001, 7'h00, 1'b0, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0,         4'b1100, 32'h0000_0003, 1'b0};
        vt[10] = '{2'b11, 3'b101, 7'h00, 1'b1, 32'h8000_0000, 32'h0,         32'h0000_0FFF, 4'b1101, 32'h0000_001F, 1'b0};
        vt[11] = '{2'b11, 3'b111, 7'h55, 1'b1, 32'h0000_00FF, 32'h0,         32'h0000_0007, 4'b0000, 32'h0000_0007, 1'b0};
        vt[12] = '{2'b10, 3'b010, 7'h00, 1'b0, 32'h0000_0042, 32'h1234_5678, 32'h0,         4'b0011, 32'h1234_5678, 1'b1};
        vt[13] = '{2'b11, 3'b101, 7'h01, 1'b1, 32'h0000_0043, 32'h0,         32'h0000_0FFF, 4'b0011, 32'h0000_0FFF, 1'b1};
        vt[14] = '{2'b10, 3'b000, 7'h01, 1'b0, 32'h0000_0044, 32'h0000_0099, 32'h0,         4'b0011, 32'h0000_0099, 1'b1};
        vt[15] = '{2'b11, 3'b011, 7'h00, 1'b1, 32'h0000_0045, 32'h0,         32'h0000_0123, 4'b0011, 32'h0000_0123, 1'b1};

        reset = 1'b1; Flush = 1'b0; OutReady = 1'b1;
        drv(1'b0, 2'b00, 3'd0, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0);
        #3;
        chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst_inready",  {31'b0, InReady},  32'd1);
        chk("rst_srca", SrcA, 32'd0);
        chk("rst_srcb", SrcB, 32'd0);
        chk("rst_operation", {28'b0, Operation}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed vectors, one per cycle with the consumer always ready
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, vt[i].aluop, vt[i].f3, vt[i].f7, vt[i].alusrc, vt[i].rs1, vt[i].rs2, vt[i].imm);
            tick();
            if (vt[i].ill && ILL_EN) begin
                chk($sformatf("vec%0d_drop", i), {31'b0, OutValid}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
                chk($sformatf("vec%0d_illegalop", i), {31'b0, IllegalOp}, 32'd1);
`endif
            end else begin
                chk($sformatf("vec%0d_valid", i), {31'b0, OutValid}, 32'd1);
                chk($sformatf("vec%0d_op", i), {28'b0, Operation}, {28'b0, vt[i].op});
                chk($sformatf("vec%0d_srca", i), SrcA, vt[i].rs1);
                chk($sformatf("vec%0d_srcb", i), SrcB, vt[i].srcb);
            end
        end
        InValid = 1'b0;
        tick(); tick();

        // backpressure: I1 in main, I2 in skid, then drain in order
        fill_both();
        tick();
        chk("bp_inready_low", {31'b0, InReady}, 32'd0);
        chk("bp_i1_held", SrcA, 32'h1111_0001);
        OutReady = 1'b1;
        tick();
        chk("bp_i2_main", SrcA, 32'h1111_0002);
        chk("bp_inready_high", {31'b0, InReady}, 32'd1);
        tick();
        chk("bp_empty", {31'b0, OutValid}, 32'd0);

        // flush with both full and a new instruction offered
        fill_both();
        drv(1'b1, 2'b00, 3'd0, 7'h00, 1'b1, 32'h1111_0003, 32'h0, 32'h30);
        Flush = 1'b1;
        tick();
        chk("flush_outvalid", {31'b0, OutValid}, 32'd0);
        chk("flush_inready", {31'b0, InReady}, 32'd1);
        Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_output", {31'b0, OutValid}, 32'd0);
        end

        // asynchronous reset between edges with both registers full
        fill_both();
        #2;
        reset = 1'b1;
        #1;
        chk("areset_outvalid", {31'b0, OutValid}, 32'd0);
        chk("areset_inready", {31'b0, InReady}, 32'd1);
        chk("areset_operation", {28'b0, Operation}, 32'd0);
        mq.delete();
        exp_ill = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        OutReady = 1'b1;
        drv(1'b1, 2'b10, 3'd4, 7'h00, 1'b0, 32'h2222_0001, 32'h0000_000F, 32'h0);
        tick();
        chk("areset_first_accept", {31'b0, OutValid}, 32'd1);
        chk("areset_first_op", {28'b0, Operation}, 32'd2);

        // random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            logic [1:0] a;
            logic [2:0] f;
            logic [6:0] f7;
            int         pick;
            a    = 2'($urandom_range(0, 3));
            f    = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 2);
            f7   = 7'($urandom);
            if (a == 2'b10) begin
                if (f == 3'd0 || f == 3'd5) f7 = (pick == 0) ? 7'h00 : (pick == 1) ? 7'h20 : 7'h01;
                else f7 = 7'h00;
            end else if (a == 2'b11 && (f == 3'd1 || f == 3'd5)) begin
                f7 = (pick == 0) ? 7'h00 : (pick == 1) ? 7'h20 : 7'h01;
            end
            drv($urandom_range(0, 9) < 7, a, f, f7, 1'($urandom), $urandom, $urandom, $urandom);
            OutReady = ($urandom_range(0, 9) < 6);
            Flush    = ($urandom_range(0, 99) < 5);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width.
REQ-002 Parameter OPCODE_LENGTH, default 4: width of Operation output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 InValid  input  1  decode stage presents an instruction.
REQ-006 InReady  output  1  block accepts the instruction this cycle when InValid&InReady.
REQ-007 ALUOp  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-008 Funct3  input  3; Funct7  input  7 (imm[11:5] for I-type).
REQ-009 ALUSrc  input  1  1 selects Imm as SrcB, 0 selects Rs2Data.
REQ-010 Rs1Data, Rs2Data, Imm  input  DATA_WIDTH each  operands, Imm already sign-extended.
REQ-011 Flush  input  1  discard all held and incoming instructions.
REQ-012 SrcA, SrcB  output  DATA_WIDTH  signed operands to ALU.
REQ-013 Operation  output  OPCODE_LENGTH  ALU op code.
REQ-014 OutValid  output  1; OutReady  input  1  execute-stage handshake.

Function
REQ-015 Op codes SHALL be: AND 0000, OR 0001, XOR 0010, ADD 0100, SUB 0101, EQ 1000, SLL 1100, SRL 1101, SRA 1110.
REQ-016 ALUOp 00 SHALL decode to ADD regardless of funct fields.
REQ-017 ALUOp 01 SHALL decode Funct3 000/001 to EQ, all other Funct3 to SUB.
REQ-018 ALUOp 10 SHALL decode: 000 ADD (Funct7=0000000) or SUB (0100000); 001 SLL; 100 XOR; 101 SRL (0000000) or SRA (0100000); 110 OR; 111 AND.
REQ-019 ALUOp 11 SHALL decode as 10 except Funct3 000 is always ADD; SLLI/SRLI require Funct7=0000000, SRAI requires 0100000.
REQ-020 Funct3 010/011 under ALUOp 10/11, or any Funct7 not listed above, SHALL be an illegal decode (REQ-033/034).
REQ-021 SrcA SHALL equal Rs1Data; SrcB SHALL equal ALUSrc ? Imm : Rs2Data, except for SLL/SRL/SRA where SrcB SHALL be zero-extended bits [4:0] of that value.
REQ-022 Datapath SHALL be a main register plus one skid register; outputs driven only from main register (registered, latency 1 cycle from accept to OutValid).
REQ-023 InReady SHALL be a register output equal to NOT skid-valid.
REQ-024 Accept with main empty, or main draining (OutValid&OutReady): load main.
REQ-025 Accept while main held (OutValid&!OutReady): load skid; InReady drops next cycle.
REQ-026 Main draining with skid valid: skid moves to main, skid clears, InReady rises next cycle.
REQ-027 Output fields SHALL remain stable while OutValid&!OutReady.
REQ-028 Order SHALL be preserved; no instruction duplicated or lost absent Flush.
REQ-029 Flush SHALL clear main-valid and skid-valid next edge, and an instruction accepted in the Flush cycle SHALL be discarded; Flush has priority over every transfer.
REQ-030 With main empty, OutValid=0 and SrcA/SrcB/Operation hold last values (don't-care to consumer).

Reset
REQ-031 Reset SHALL asynchronously force OutValid=0, skid-valid=0, InReady=1, SrcA=0, SrcB=0, Operation=0000.
REQ-032 Reset asserted mid-transfer SHALL drop both held instructions; first accept allowed on first edge after deassertion.

Configuration
REQ-033 With ALU_ISSUE_ILLEGAL_EN defined: output IllegalOp (1 bit, registered, reset 0) SHALL pulse one cycle for each accepted illegal decode, and that instruction SHALL be dropped (never reaches OutValid).
REQ-034 Without ALU_ISSUE_ILLEGAL_EN: no IllegalOp port; illegal decodes SHALL pass through with Operation=0011 (ALU yields 0).

Verification
REQ-035 ALUOp=10, Funct3=101, Funct7=0100000, Rs1=0x80000000, Rs2=0x24, ALUSrc=0, OutReady=1 -> next cycle OutValid=1, Operation=1110, SrcB=0x00000004.
REQ-036 ALUOp=11, Funct3=000, Funct7=0100000, Imm=0xFFFFFFFF, ALUSrc=1 -> Operation=0100, SrcB=0xFFFFFFFF.
REQ-037 OutReady=0, issue I1,I2 back-to-back -> I1 held in main, I2 in skid, InReady=0; raise OutReady -> I1 then I2 on consecutive cycles, InReady=1 cycle after I2 moves to main.
REQ-038 Main and skid full, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, no later output of any of the three.
REQ-039 ALUOp=10, Funct3=010 -> with ALU_ISSUE_ILLEGAL_EN: IllegalOp=1 one cycle, OutValid=0; without: OutValid=1, Operation=0011.
REQ-040 Reset asserted asynchronously between edges with both registers full -> OutValid=0, InReady=1 immediately, Operation=0000.
